// File: rtl/packet_tx_scheduler.sv
// Packet TX scheduler: arbitrates the composer datapath between TCHECK, FLUSH
// and PUT packets, one packet at a time with an inter-packet gap, and also
// produces the periodic termination-check tick and the flush-pass completion.
module packet_tx_scheduler #(
    parameter int TICK_PERIOD  = 125000000,
    parameter int STARVE_LIMIT = 4,
    parameter int GAP_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tcheck_req,
    input  logic                 flush_req,
    input  logic                 put_req,
    input  logic [31:0]          num_keys,
    input  logic [GAP_WIDTH-1:0] interpkt_gap_cycles,
    input  logic                 tick_enable,
    input  logic                 pkt_done,
    output logic [2:0]           grant,
    output logic                 busy,
    output logic                 tick,
    output logic                 flush_complete
);

    localparam int TICK_W   = $clog2(TICK_PERIOD);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(TICK_PERIOD - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            grant_q, grant_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [31:0]           flushed_q, flushed_d;
    logic                  flush_complete_q, flush_complete_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic                  tick_q, tick_d;

    logic [2:0]            win;
    logic                  flush_ok;
    logic                  put_starved;

    // Pick the request that would be granted this cycle if the FSM is idle.
    always_comb begin
        win         = 3'b000;
        flush_ok    = flush_req && (num_keys != 32'd0);
        put_starved = put_req && (starve_q == STARVE_MAX);
        if (tcheck_req) begin
            win = 3'b001;
        end else if (put_starved) begin
            win = 3'b100;
        end else if (flush_ok) begin
            win = 3'b010;
        end else if (put_req) begin
            win = 3'b100;
        end
    end

    // Packet sequencing FSM, starvation counter and flush-pass bookkeeping.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        gap_d            = gap_q;
        starve_d         = starve_q;
        flushed_d        = flushed_q;
        flush_complete_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win != 3'b000) begin
                    grant_d = win;
                    state_d = GRANT;
                end
                // PUT grant resets the starvation count; FLUSH grants bump it.
                if (win[2]) begin
                    starve_d = '0;
                end else if (win[1]) begin
                    if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (!put_req) begin
                    starve_d = '0;
                end
            end
            GRANT: begin
                if (pkt_done) begin
                    grant_d = 3'b000;
                    if (grant_q[1]) begin
                        if (flushed_q + 32'd1 == num_keys) begin
                            flushed_d        = '0;
                            flush_complete_d = 1'b1;
                        end else begin
                            flushed_d = flushed_q + 32'd1;
                        end
                    end
                    // The gap length is latched here so later changes cannot stretch it.
                    if (interpkt_gap_cycles == '0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = interpkt_gap_cycles;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - GAP_WIDTH'(1);
                if (gap_q == GAP_WIDTH'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    // Free-running tick counter; disabled means parked at zero with no pulse.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;
        if (!tick_enable) begin
            tick_cnt_d = '0;
        end else if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    // State registers; reset aborts any packet in flight immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            grant_q          <= 3'b000;
            gap_q            <= '0;
            starve_q         <= '0;
            flushed_q        <= '0;
            flush_complete_q <= 1'b0;
            tick_cnt_q       <= '0;
            tick_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            gap_q            <= gap_d;
            starve_q         <= starve_d;
            flushed_q        <= flushed_d;
            flush_complete_q <= flush_complete_d;
            tick_cnt_q       <= tick_cnt_d;
            tick_q           <= tick_d;
        end
    end

    assign grant          = grant_q;
    assign busy           = (state_q != IDLE);
    assign tick           = tick_q;
    assign flush_complete = flush_complete_q;

endmodule

// File: tb/tb_packet_tx_scheduler.sv
// Bench for packet_tx_scheduler: a cycle-level behavioural model checked
// against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_packet_tx_scheduler;

    localparam int TP  = 10;
    localparam int SL  = 4;
    localparam int GW  = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          tcheck_req = 1'b0;
    logic          flush_req = 1'b0;
    logic          put_req = 1'b0;
    logic [31:0]   num_keys = 32'd0;
    logic [GW-1:0] interpkt_gap_cycles = '0;
    logic          tick_enable = 1'b0;
    logic          pkt_done = 1'b0;
    logic [2:0]    grant;
    logic          busy;
    logic          tick;
    logic          flush_complete;

    int total = 0;
    int bad = 0;
    int fc_seen = 0;

    packet_tx_scheduler #(
        .TICK_PERIOD (TP),
        .STARVE_LIMIT(SL),
        .GAP_WIDTH   (GW)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .tcheck_req         (tcheck_req),
        .flush_req          (flush_req),
        .put_req            (put_req),
        .num_keys           (num_keys),
        .interpkt_gap_cycles(interpkt_gap_cycles),
        .tick_enable        (tick_enable),
        .pkt_done           (pkt_done),
        .grant              (grant),
        .busy               (busy),
        .tick               (tick),
        .flush_complete     (flush_complete)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the packet currently granted (0 = none), remaining gap cycles,
    // flushes since the last PUT, keys flushed in this pass and the tick phase.
    int m_grant = 0, m_gap = 0, m_starve = 0, m_flushed = 0, m_fc = 0;
    int m_tcnt = 0, m_tick = 0;

    function automatic int pick(input bit tc, input bit fl, input bit pt, input int nk, input int starve);
        bit fl_ok;
        fl_ok = fl && (nk != 0);
        if (tc) return 1;
        if (pt && starve == SL) return 4;
        if (fl_ok) return 2;
        if (pt) return 4;
        return 0;
    endfunction

    initial forever begin
        int win;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_grant = 0; m_gap = 0; m_starve = 0; m_flushed = 0; m_fc = 0;
            m_tcnt = 0; m_tick = 0;
        end else begin
            m_fc = 0;
            if (m_grant != 0) begin
                if (pkt_done) begin
                    if (m_grant == 2) begin
                        if (m_flushed + 1 == int'(num_keys)) begin
                            m_fc = 1;
                            m_flushed = 0;
                        end else begin
                            m_flushed++;
                        end
                    end
                    m_gap = int'(interpkt_gap_cycles);
                    m_grant = 0;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                win = pick(tcheck_req, flush_req, put_req, int'(num_keys), m_starve);
                m_grant = win;
                if (win == 4) m_starve = 0;
                else if (win == 2) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
                else if (!put_req) m_starve = 0;
            end
            if (!tick_enable) begin
                m_tcnt = 0;
                m_tick = 0;
            end else begin
                m_tick = (m_tcnt == TP - 1) ? 1 : 0;
                m_tcnt = (m_tcnt + 1) % TP;
            end
        end
    end

    // Per-cycle comparison against the model, sampled 1 time unit after the edge.
    initial forever begin
        @(posedge clk);
        #1;
        chk("cyc_grant", 32'(grant), 32'(m_grant));
        chk("cyc_busy", 32'(busy), (m_grant != 0 || m_gap > 0) ? 32'd1 : 32'd0);
        chk("cyc_tick", 32'(tick), 32'(m_tick));
        chk("cyc_flush_complete", 32'(flush_complete), 32'(m_fc));
        if (flush_complete) fc_seen++;
    end

    // ---------------- helpers ----------------
    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_grant(input string name, output logic [2:0] g);
        g = 3'b000;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (grant != 3'b000) begin
                g = grant;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s: got no grant expected a grant within 100 cycles", name);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [2:0] g;
        int k, idle_n, nz, base;
        int pos[$];
        logic [2:0] exp_seq [10];

        // 1: reset with all requests high
        tcheck_req = 1'b1; flush_req = 1'b1; put_req = 1'b1;
        num_keys = 32'd3; interpkt_gap_cycles = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_rst_grant", 32'(grant), 32'd0);
        chk("t1_rst_busy", 32'(busy), 32'd0);
        chk("t1_rst_tick", 32'(tick), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t1_grant_after_release", 32'(grant), 32'd1);
        chk("t1_busy_after_release", 32'(busy), 32'd1);
        tcheck_req = 1'b0; flush_req = 1'b0; put_req = 1'b0;
        pulse_done();

        // 2: priority and inter-packet gap of 5
        interpkt_gap_cycles = 32'd5;
        tcheck_req = 1'b1; flush_req = 1'b1; put_req = 1'b1;
        apply_reset();
        wait_grant("t2_first", g);
        chk("t2_first_is_tcheck", 32'(g), 32'd1);
        @(negedge clk);
        tcheck_req = 1'b0;
        pkt_done = 1'b1;
        @(posedge clk);
        #1;
        chk("t2_grant_cleared", 32'(grant), 32'd0);
        chk("t2_busy_in_gap", 32'(busy), 32'd1);
        @(negedge clk);
        pkt_done = 1'b0;
        k = 0; idle_n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) interpkt_gap_cycles = 32'd100;
            if (!busy) idle_n++;
            if (grant != 3'b000) begin
                k = i;
                break;
            end
        end
        chk("t2_cycles_to_next_grant", 32'(k), 32'd6);
        chk("t2_idle_cycles", 32'(idle_n), 32'd1);
        chk("t2_second_is_flush", 32'(grant), 32'd2);
        interpkt_gap_cycles = '0;

        // 3: starvation: flush x4 then put, twice
        tcheck_req = 1'b0; flush_req = 1'b1; put_req = 1'b1;
        num_keys = 32'd1000; interpkt_gap_cycles = '0;
        apply_reset();
        exp_seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100,
                    3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
        for (int i = 0; i < 10; i++) begin
            wait_grant("t3_wait", g);
            chk($sformatf("t3_seq%0d", i), 32'(g), 32'(exp_seq[i]));
            pulse_done();
        end

        // 4: flush pass of 3 keys, then num_keys=0 masks FLUSH
        tcheck_req = 1'b0; flush_req = 1'b1; put_req = 1'b0;
        num_keys = 32'd3; interpkt_gap_cycles = 32'd1;
        apply_reset();
        base = fc_seen;
        for (int i = 0; i < 3; i++) begin
            wait_grant("t4_wait", g);
            chk($sformatf("t4_grant%0d", i), 32'(g), 32'd2);
            @(negedge clk);
            pkt_done = 1'b1;
            if (i == 2) flush_req = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("t4_fc_after%0d", i), 32'(flush_complete), (i == 2) ? 32'd1 : 32'd0);
            @(negedge clk);
            pkt_done = 1'b0;
        end
        num_keys = 32'd0;
        flush_req = 1'b1;
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (grant != 3'b000) nz++;
        end
        chk("t4_no_flush_when_zero_keys", 32'(nz), 32'd0);
        chk("t4_fc_pulses", 32'(fc_seen - base), 32'd1);
        flush_req = 1'b0;

        // 5: tick period 10
        apply_reset();
        @(negedge clk);
        tick_enable = 1'b1;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk);
            #1;
            if (tick) pos.push_back(c);
        end
        chk("t5_tick_count", 32'(pos.size()), 32'd3);
        chk("t5_tick0_pos", (pos.size() > 0) ? 32'(pos[0]) : 32'hFFFF, 32'd9);
        chk("t5_tick1_pos", (pos.size() > 1) ? 32'(pos[1]) : 32'hFFFF, 32'd19);
        chk("t5_tick2_pos", (pos.size() > 2) ? 32'(pos[2]) : 32'hFFFF, 32'd29);
        @(negedge clk);
        tick_enable = 1'b0;
        nz = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (tick) nz++;
        end
        chk("t5_no_tick_disabled", 32'(nz), 32'd0);
        @(negedge clk);
        tick_enable = 1'b1;
        k = -1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (tick && k < 0) k = c;
        end
        chk("t5_restart_from_zero", 32'(k), 32'd9);
        @(negedge clk);
        tick_enable = 1'b0;

        // 6: reset mid-packet and stray pkt_done
        interpkt_gap_cycles = 32'd3;
        put_req = 1'b1;
        apply_reset();
        wait_grant("t6_wait", g);
        chk("t6_put_granted", 32'(g), 32'd4);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_grant", 32'(grant), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        put_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pulse_done();
        @(posedge clk);
        #1;
        chk("t6_stray_busy", 32'(busy), 32'd0);
        chk("t6_stray_grant", 32'(grant), 32'd0);
        @(negedge clk);
        put_req = 1'b1;
        wait_grant("t6_wait2", g);
        chk("t6_put_regranted", 32'(g), 32'd4);
        pulse_done();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
